fp_div_arbiter: RTL and testbench
=================================

FP_DIV_ARBITER -- requirements
Module: fp_div_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 55, the divider operand and quotient width.
REQ-002 The block SHALL have parameter TAG_WIDTH, default 3, the instruction ID width carried per request.
REQ-003 The block SHALL have these ports (name, direction, width, meaning), one per line:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
flush  in  1  discard all in-flight and held work
req_valid  in  2  per-port request valid
req_ready  out  2  per-port request accepted
req_dividend  in  2xDATA_WIDTH  per-port dividend
req_divisor  in  2x(DATA_WIDTH)  per-port divisor
req_tag  in  2xTAG_WIDTH  per-port ID
core_start  out  1  one-cycle start pulse to the divider core
core_dividend  out  DATA_WIDTH  dividend for the core
core_divisor  out  DATA_WIDTH  divisor for the core
core_done  in  1  one-cycle completion pulse
core_quotient  in  DATA_WIDTH  core quotient, stable from done until next start
core_remainder  in  DATA_WIDTH  core remainder, stable from done until next start
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_port  out  1  originating port
rsp_tag  out  TAG_WIDTH  originating ID
rsp_quotient  out  DATA_WIDTH  quotient
rsp_sticky  out  1  OR-reduction of the remainder (inexact flag)

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, BUSY, WAIT_OUT and DRAIN.
REQ-005 In IDLE with flush=0, a grant SHALL occur when any req_valid is 1.
REQ-006 On a grant, req_ready SHALL be one-hot for the granted port.
REQ-007 On a grant, core_start SHALL be 1 in the same cycle.
REQ-008 On a grant, core_dividend and core_divisor SHALL be driven combinationally from the granted port.
REQ-009 On a grant, the tag and port SHALL be latched, and the state SHALL go to BUSY.
REQ-010 In every other state or cycle, req_ready and core_start SHALL be 0.
REQ-011 Arbitration SHALL be round-robin.
REQ-012 The priority pointer SHALL reset to port 0 and SHALL move to the non-granted port after each grant.
REQ-013 When only one port is valid, that port SHALL be granted regardless of the pointer.
REQ-014 In BUSY on core_done with the output register empty, or being emptied this cycle (rsp_valid&rsp_ready), the block SHALL capture the result and return to IDLE.
REQ-015 The capture SHALL register quotient, sticky (|core_remainder), tag and port, and SHALL set rsp_valid on the next cycle.
REQ-016 In BUSY on core_done with the output register occupied and not draining, the state SHALL go to WAIT_OUT.
REQ-017 WAIT_OUT SHALL capture from core_quotient/core_remainder in the first cycle the output frees, then go to IDLE.
REQ-018 rsp_valid SHALL hold, and the rsp_* fields SHALL remain stable, until rsp_valid&rsp_ready.
REQ-019 A grant SHALL be permitted in IDLE while rsp_valid is held.
REQ-020 flush in BUSY SHALL go to DRAIN.
REQ-021 DRAIN SHALL wait for core_done, discard the result, then go to IDLE.
REQ-022 flush in WAIT_OUT SHALL go to IDLE with no capture.
REQ-023 flush SHALL clear rsp_valid in the same edge.
REQ-024 flush SHALL suppress any grant in that cycle.
REQ-025 A core_done arriving in IDLE (spurious) SHALL be ignored.
REQ-026 Minimum request-to-rsp_valid latency SHALL be core latency + 1 cycle.

Reset
REQ-027 Reset SHALL set the state to IDLE, rsp_valid=0, core_start=0, req_ready=0 and pointer=0.
REQ-028 Reset SHALL set rsp_quotient, rsp_tag, rsp_port and rsp_sticky to 0.
REQ-029 Reset mid-operation SHALL abandon the in-flight op without waiting for core_done.
REQ-030 The divider core SHALL be reset by the same rst.

Structure
REQ-031 A request struct (dividend, divisor, tag) SHALL be defined in the shared fpu_types package.
REQ-032 The FSM state enum SHALL be local to the module.
REQ-033 The 2-way round-robin grant logic SHALL be a sub-module, fp_div_rr_arbiter (req[1:0], advance, grant[1:0]).

Verification
REQ-034 The bench core model SHALL assert done 31 cycles after start (DATA_WIDTH=55).
REQ-035 Scenario: port0 request dividend=0x0C..0, divisor=0x08..0, tag=5, rsp_ready=1 -> core_start at cycle 0, rsp_valid at cycle 32, rsp_tag=5, rsp_port=0.
REQ-036 Scenario: both ports valid continuously for 4 ops -> grant order 0,1,0,1, with no cycle where both req_ready bits are set.
REQ-037 Scenario: rsp_ready=0 for 50 cycles with a second op issued -> WAIT_OUT entered; after rsp_ready=1, both results delivered in order with correct tags.
REQ-038 Scenario: flush 10 cycles after start -> no rsp_valid for that op; next request granted only after the drained core_done.
REQ-039 Scenario: remainder nonzero versus zero (dividend=divisor) -> rsp_sticky=1 and rsp_sticky=0 respectively.
REQ-040 Scenario: rst asserted mid-BUSY -> all outputs 0 next cycle; a new request is granted immediately.

Source files
------------

// File: rtl/fpu_types.sv
// Shared FPU types: divider request layout and default datapath widths.
package fpu_types;

  localparam int unsigned FPU_DIV_WIDTH = 55;
  localparam int unsigned FPU_TAG_WIDTH = 3;
  localparam int unsigned FPU_DIV_PORTS = 2;

  typedef struct packed {
    logic [FPU_DIV_WIDTH-1:0] dividend;
    logic [FPU_DIV_WIDTH-1:0] divisor;
    logic [FPU_TAG_WIDTH-1:0] tag;
  } fpu_div_req_t;

endpackage

// File: rtl/fp_div_rr_arbiter.sv
// Two-way round-robin grant; the pointer names the port that wins a tie.
module fp_div_rr_arbiter
  import fpu_types::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FPU_DIV_PORTS-1:0] req,
  input  logic                     advance,
  output logic [FPU_DIV_PORTS-1:0] grant
);

  logic r_ptr;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = r_ptr ? 2'b10 : 2'b01;
    end
  end

  // After a grant the other port gets priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (advance) begin
      r_ptr <= grant[0];
    end
  end

endmodule

// File: rtl/fp_div_arbiter.sv
// Shares one multi-cycle divider core between two request ports and buffers one result.
module fp_div_arbiter
  import fpu_types::*;
#(
  parameter int unsigned DATA_WIDTH = FPU_DIV_WIDTH,
  parameter int unsigned TAG_WIDTH  = FPU_TAG_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [FPU_DIV_PORTS-1:0]            req_valid,
  output logic [FPU_DIV_PORTS-1:0]            req_ready,
  input  logic [FPU_DIV_PORTS*DATA_WIDTH-1:0] req_dividend,
  input  logic [FPU_DIV_PORTS*DATA_WIDTH-1:0] req_divisor,
  input  logic [FPU_DIV_PORTS*TAG_WIDTH-1:0]  req_tag,
  output logic                                core_start,
  output logic [DATA_WIDTH-1:0]               core_dividend,
  output logic [DATA_WIDTH-1:0]               core_divisor,
  input  logic                                core_done,
  input  logic [DATA_WIDTH-1:0]               core_quotient,
  input  logic [DATA_WIDTH-1:0]               core_remainder,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic                                rsp_port,
  output logic [TAG_WIDTH-1:0]                rsp_tag,
  output logic [DATA_WIDTH-1:0]               rsp_quotient,
  output logic                                rsp_sticky
);

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_OUT, DRAIN} state_t;

  state_t                  r_state;
  logic [TAG_WIDTH-1:0]    r_tag;
  logic                    r_port;
  logic                    r_rsp_valid;
  logic                    r_rsp_port;
  logic [TAG_WIDTH-1:0]    r_rsp_tag;
  logic [DATA_WIDTH-1:0]   r_rsp_quotient;
  logic                    r_rsp_sticky;

  logic [FPU_DIV_PORTS-1:0] w_grant;
  logic                     w_gport;
  logic                     w_grant_en;
  logic                     w_out_free;
  logic                     w_capture;
  fpu_div_req_t             w_sel;

  fp_div_rr_arbiter u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (w_grant_en),
    .grant   (w_grant)
  );

  always_comb begin
    w_gport        = w_grant[1];
    w_sel.dividend = FPU_DIV_WIDTH'(w_gport ? req_dividend[2*DATA_WIDTH-1:DATA_WIDTH]
                                            : req_dividend[DATA_WIDTH-1:0]);
    w_sel.divisor  = FPU_DIV_WIDTH'(w_gport ? req_divisor[2*DATA_WIDTH-1:DATA_WIDTH]
                                            : req_divisor[DATA_WIDTH-1:0]);
    w_sel.tag      = FPU_TAG_WIDTH'(w_gport ? req_tag[2*TAG_WIDTH-1:TAG_WIDTH]
                                            : req_tag[TAG_WIDTH-1:0]);
  end

  // The output slot frees either when empty or when the consumer takes it this cycle.
  assign w_out_free = !r_rsp_valid || rsp_ready;
  assign w_grant_en = (r_state == IDLE) && !flush && !rst && (|req_valid);
  assign w_capture  = !flush && w_out_free &&
                      (((r_state == BUSY) && core_done) || (r_state == WAIT_OUT));

  assign req_ready     = w_grant_en ? w_grant : '0;
  assign core_start    = w_grant_en;
  assign core_dividend = w_sel.dividend[DATA_WIDTH-1:0];
  assign core_divisor  = w_sel.divisor[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_tag          <= '0;
      r_port         <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_port     <= 1'b0;
      r_rsp_tag      <= '0;
      r_rsp_quotient <= '0;
      r_rsp_sticky   <= 1'b0;
    end else begin
      if (flush) begin
        r_rsp_valid <= 1'b0;
      end else if (w_capture) begin
        r_rsp_valid <= 1'b1;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end

      if (w_capture) begin
        r_rsp_quotient <= core_quotient;
        r_rsp_sticky   <= |core_remainder;
        r_rsp_tag      <= r_tag;
        r_rsp_port     <= r_port;
      end

      case (r_state)
        IDLE: begin
          if (w_grant_en) begin
            r_tag   <= w_sel.tag[TAG_WIDTH-1:0];
            r_port  <= w_gport;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          // A done coinciding with flush is already the drained completion.
          if (flush) begin
            r_state <= core_done ? IDLE : DRAIN;
          end else if (core_done) begin
            r_state <= w_out_free ? IDLE : WAIT_OUT;
          end
        end
        WAIT_OUT: begin
          if (flush || w_out_free) begin
            r_state <= IDLE;
          end
        end
        DRAIN: begin
          if (core_done) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_port     = r_rsp_port;
  assign rsp_tag      = r_rsp_tag;
  assign rsp_quotient = r_rsp_quotient;
  assign rsp_sticky   = r_rsp_sticky;

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed bench for fp_div_arbiter with a 31-cycle behavioural divider core.
module tb_fp_div_arbiter;

  localparam int DW = 55;
  localparam int TW = 3;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*DW-1:0] req_dividend;
  logic [2*DW-1:0] req_divisor;
  logic [2*TW-1:0] req_tag;
  logic            core_start;
  logic [DW-1:0]   core_dividend;
  logic [DW-1:0]   core_divisor;
  logic            core_done;
  logic [DW-1:0]   core_quotient;
  logic [DW-1:0]   core_remainder;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_port;
  logic [TW-1:0]   rsp_tag;
  logic [DW-1:0]   rsp_quotient;
  logic            rsp_sticky;

  fp_div_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dividend   (req_dividend),
    .req_divisor    (req_divisor),
    .req_tag        (req_tag),
    .core_start     (core_start),
    .core_dividend  (core_dividend),
    .core_divisor   (core_divisor),
    .core_done      (core_done),
    .core_quotient  (core_quotient),
    .core_remainder (core_remainder),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_port       (rsp_port),
    .rsp_tag        (rsp_tag),
    .rsp_quotient   (rsp_quotient),
    .rsp_sticky     (rsp_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider core: done exactly 31 cycles after start, reset by the same rst.
  logic [DW-1:0] m_q, m_r;
  logic          m_busy;
  int            m_cnt;
  logic          spur_done;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (core_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 30;
      m_q    <= core_dividend / core_divisor;
      m_r    <= core_dividend % core_divisor;
    end else if (m_busy) begin
      if (m_cnt == 0) m_busy <= 1'b0;
      else m_cnt <= m_cnt - 1;
    end
  end

  assign core_done      = (m_busy && (m_cnt == 0)) || spur_done;
  assign core_quotient  = m_q;
  assign core_remainder = m_r;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [DW-1:0] dd, input logic [DW-1:0] dv,
                         input logic [TW-1:0] tg);
    req_dividend[p*DW +: DW] = dd;
    req_divisor[p*DW +: DW]  = dv;
    req_tag[p*TW +: TW]      = tg;
    req_valid[p]             = 1'b1;
  endtask

  // Called in the input phase; returns in the input phase of the cycle after the grant.
  task automatic issue(input int p, input logic [DW-1:0] dd, input logic [DW-1:0] dv,
                       input logic [TW-1:0] tg, output int t);
    t = -1;
    set_req(p, dd, dv, tg);
    for (int i = 0; i < 200 && t < 0; i++) begin
      @(negedge clk);
      if (req_ready[p]) begin
        t = cyc;
        check("issue_ready", 64'(req_ready), 64'(2'(1) << p));
        check("issue_start", 64'(core_start), 64'd1);
        check("issue_dividend", 64'(core_dividend), 64'(dd));
      end
      @(posedge clk); #1;
    end
    req_valid[p] = 1'b0;
    if (t < 0) check("issue_timeout", 64'd0, 64'd1);
  endtask

  // Returns at the negedge of the first cycle with rsp_valid set.
  task automatic wait_rsp(output int t);
    t = -1;
    for (int i = 0; i < 200 && t < 0; i++) begin
      @(negedge clk);
      if (rsp_valid) t = cyc;
      else begin
        @(posedge clk); #1;
      end
    end
    if (t < 0) check("rsp_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int t0, t1, tg, seen;
  int ng, nr;
  int gport [4];
  logic [TW-1:0] rtag [4];
  logic [DW-1:0] rquot [4];
  logic          rstk [4];
  logic [DW-1:0] d_a, d_b;

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_dividend = '0; req_divisor = '0;
    req_tag = '0; rsp_ready = 1'b1; spur_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    check("rst_rsp_quot", 64'(rsp_quotient), 64'd0);
    check("rst_rsp_port", 64'(rsp_port), 64'd0);
    check("rst_rsp_sticky", 64'(rsp_sticky), 64'd0);
    @(posedge clk); #1;

    // Spurious done in IDLE is ignored
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    @(negedge clk);
    check("spurious_done", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;

    // Single op, port 0: latency 32, remainder nonzero
    d_a = 55'd12 << 50;
    d_b = 55'd8 << 50;
    issue(0, d_a, d_b, 3'd5, t0);
    wait_rsp(t1);
    check("lat", 64'(t1 - t0), 64'd32);
    check("s1_tag", 64'(rsp_tag), 64'd5);
    check("s1_port", 64'(rsp_port), 64'd0);
    check("s1_quot", 64'(rsp_quotient), 64'd1);
    check("s1_sticky", 64'(rsp_sticky), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("s1_consumed", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;

    // Exact division on port 1: sticky clear
    issue(1, 55'd100, 55'd100, 3'd2, t0);
    wait_rsp(t1);
    check("s2_tag", 64'(rsp_tag), 64'd2);
    check("s2_port", 64'(rsp_port), 64'd1);
    check("s2_quot", 64'(rsp_quotient), 64'd1);
    check("s2_sticky", 64'(rsp_sticky), 64'd0);
    @(posedge clk); #1;

    // Round robin with both ports continuously valid
    set_req(0, 55'd1000, 55'd7, 3'd1);
    set_req(1, 55'd64, 55'd8, 3'd6);
    ng = 0; nr = 0;
    for (int c = 0; c < 400 && nr < 4; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        check("rr_onehot", 64'($onehot(req_ready)), 64'd1);
        if (ng < 4) gport[ng] = req_ready[1] ? 1 : 0;
        ng++;
      end
      if (rsp_valid && rsp_ready) begin
        if (nr < 4) begin
          rtag[nr] = rsp_tag; rquot[nr] = rsp_quotient; rstk[nr] = rsp_sticky;
        end
        nr++;
      end
      @(posedge clk); #1;
      if (ng >= 4) req_valid = 2'b00;
    end
    check("rr_grants", 64'(ng), 64'd4);
    check("rr_rsps", 64'(nr), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check("rr_order", 64'(gport[k]), 64'(k % 2));
      check("rr_tag", 64'(rtag[k]), (k % 2 == 0) ? 64'd1 : 64'd6);
      check("rr_quot", 64'(rquot[k]), (k % 2 == 0) ? 64'd142 : 64'd8);
      check("rr_sticky", 64'(rstk[k]), (k % 2 == 0) ? 64'd1 : 64'd0);
    end

    // Consumer stalls: second op completes into WAIT_OUT, both delivered in order
    rsp_ready = 1'b0;
    issue(0, 55'd1000, 55'd7, 3'd3, t0);
    wait_rsp(t1);
    @(posedge clk); #1;
    issue(1, 55'd64, 55'd8, 3'd4, tg);
    check("grant_while_held", 64'(tg), 64'(t1 + 1));
    repeat (40) @(posedge clk);
    #1 set_req(0, 55'd9, 55'd3, 3'd7);
    @(negedge clk);
    check("waitout_no_grant", 64'(req_ready), 64'd0);
    check("held_valid", 64'(rsp_valid), 64'd1);
    check("held_tag", 64'(rsp_tag), 64'd3);
    check("held_quot", 64'(rsp_quotient), 64'd142);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("wo_first_tag", 64'(rsp_tag), 64'd3);
    @(posedge clk); #1;
    @(negedge clk);
    check("wo_second_valid", 64'(rsp_valid), 64'd1);
    check("wo_second_tag", 64'(rsp_tag), 64'd4);
    check("wo_second_port", 64'(rsp_port), 64'd1);
    check("wo_second_quot", 64'(rsp_quotient), 64'd8);
    @(posedge clk); #1;
    @(negedge clk);
    check("wo_drained", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;

    // Flush in BUSY: result dropped, next grant only after the drained done
    issue(0, 55'd50, 55'd5, 3'd7, t0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    set_req(1, 55'd300, 55'd10, 3'd2);
    @(negedge clk);
    check("flush_no_grant", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    tg = -1; seen = 0;
    for (int i = 0; i < 100 && tg < 0; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
      if (req_ready[1]) tg = cyc;
      @(posedge clk); #1;
    end
    req_valid[1] = 1'b0;
    check("flush_grant_cycle", 64'(tg), 64'(t0 + 32));
    check("flush_no_rsp", 64'(seen), 64'd0);
    wait_rsp(t1);
    check("post_flush_tag", 64'(rsp_tag), 64'd2);
    check("post_flush_quot", 64'(rsp_quotient), 64'd30);
    check("post_flush_lat", 64'(t1 - tg), 64'd32);
    @(posedge clk); #1;

    // Flush in IDLE clears a held result and suppresses a grant
    rsp_ready = 1'b0;
    issue(0, 55'd9, 55'd3, 3'd1, t0);
    wait_rsp(t1);
    @(posedge clk); #1;
    flush = 1'b1;
    req_valid[1] = 1'b1;
    @(negedge clk);
    check("idle_flush_no_grant", 64'(req_ready), 64'd0);
    check("idle_flush_no_start", 64'(core_start), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("flush_clears_rsp", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;

    // Reset mid-BUSY abandons the op and clears the result register
    issue(1, 55'd77, 55'd7, 3'd6, t0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    check("mid_rst_start", 64'(core_start), 64'd0);
    check("mid_rst_tag", 64'(rsp_tag), 64'd0);
    check("mid_rst_quot", 64'(rsp_quotient), 64'd0);
    @(posedge clk); #1;
    t1 = cyc;
    issue(1, 55'd90, 55'd9, 3'd4, tg);
    check("post_rst_grant", 64'(tg), 64'(t1));
    wait_rsp(t1);
    check("post_rst_tag", 64'(rsp_tag), 64'd4);
    check("post_rst_quot", 64'(rsp_quotient), 64'd10);
    check("post_rst_lat", 64'(t1 - tg), 64'd32);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
